phase_accumulator: RTL and testbench
====================================

# phase_accumulator

Pipelined 24-bit DDS phase accumulator that produces the MSB/ISB/LSB phase bytes consumed directly by the phase-offset adder stage. The accumulator is built from three 8-bit slices with a registered carry between slices, so no adder is wider than 8 bits in a single cycle. Output deskew registers align the slices so that every output word is a coherent 24-bit phase. A ready/valid handshake loads a new frequency tuning word (FTW) and applies it to the slices in a staggered order, so the FTW change is seen atomically at the output.

## Interface
- No parameters. Widths are fixed: 24-bit phase, 3 × 8-bit slices.
- i_clk  in  1  sole clock; all state updates on its rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_ftw  in  24  new frequency tuning word.
- i_ftw_valid  in  1  FTW offer strobe.
- o_ftw_ready  out  1  block can accept an FTW.
- i_acc_en  in  1  accumulation step enable. When low, every pipeline/staging register holds.
- i_acc_clr  in  1  synchronous phase clear.
- o_msb  out  8  phase bits [23:16].
- o_isb  out  8  phase bits [15:8].
- o_lsb  out  8  phase bits [7:0].
- o_valid  out  1  output word is a defined accumulator value (pipeline filled).
- o_wrap  out  1  the output word results from a step that overflowed 2^24.

## Operation
- **Priority:** i_rst > i_acc_clr > FTW acceptance/enabled step.
- **Reference model.** Let F(k) be the FTW in force at enabled step k. Define A(0)=0 and A(k+1)=(A(k)+F(k)) mod 2^24.
  - After k enabled steps since reset/clear, {o_msb,o_isb,o_lsb} = A(k-2) for k≥2, and 0 for k<2.
- **Slice L.** L <= L + fL; c0 <= carry.
- **Slice I.** I <= I + fI + c0; c1 <= carry.
- **Slice M.** M <= M + fM + c1; cw <= carry.
  - This gives L = A(k)[7:0], I = A(k-1)[15:8], M = A(k-2)[23:16].
- **Deskew.**
  - o_lsb = L delayed 2 enabled steps.
  - o_isb = I delayed 1 enabled step.
  - o_msb = M.
  - o_wrap = cw, which is aligned with o_msb.
- **o_valid.** Goes high after the 2nd enabled step following reset/clear. It stays high until the next reset/clear.
- **FTW handshake.**
  - Acceptance = i_ftw_valid & o_ftw_ready, at cycle t.
  - At t: fL <= i_ftw[7:0]. Bytes [23:8] are captured into a pending register, and the stage counter is set to 2. This happens regardless of i_acc_en.
  - At each later enabled step:
    - Counter 2 → fI <= pending[15:8], counter → 1.
    - Counter 1 → fM <= pending[23:16], counter → 0.
  - o_ftw_ready = (counter == 0).
  - While the counter is nonzero, i_ftw_valid is ignored and the offered value is held by the source.
- **State machine.** IDLE (ready=1) → STAGE_I → STAGE_M → IDLE. STAGE_I and STAGE_M advance only on enabled steps.
- **i_acc_clr.**
  - Zeros L, I, M, c0, c1, cw, all deskew registers and the step count. o_valid → 0 and o_wrap → 0 on the next cycle.
  - A pending FTW completes immediately: fI and fM are loaded from pending and the state goes to IDLE. fL, fI and fM are otherwise retained.
  - If i_acc_clr and an FTW offer coincide, the offer is accepted and fully applied, with fL, fI and fM all loaded at once.
- **Wrap-around.** Modulo 2^24 with no saturation. o_wrap is 1 only on the output word whose step produced the carry out of bit 23.

## Timing
- **Reset values.**
  - Outputs: o_msb = o_isb = o_lsb = 0, o_valid = 0, o_wrap = 0, o_ftw_ready = 1.
  - Internal: fL = fI = fM = 0, state IDLE.
- **Latency.**
  - An FTW accepted at cycle t, with i_acc_en held high, first affects the output word presented after the 3rd rising edge following t.
  - Increments of the old FTW are never mixed with the new one within one output word.
- **Ready timing.** o_ftw_ready is low for exactly 2 enabled steps after acceptance. With continuous enable it returns high 2 cycles after t.
- **Throughput.** One output word per enabled cycle. With i_acc_en low, the outputs and o_valid hold their values.
- **Reset mid-operation.** Reset at any point, including mid-staging, returns every register to its reset value on the next edge. The pending FTW is discarded.

## Test plan
- **Ramp.** Reset, FTW=0x000001, enable continuously. Required output sequence: 0, 0, 0, 1, 2, 3, …; o_valid rises on the 3rd output.
- **Carry propagation.** FTW=0x0000FF, run 300 steps. Every output equals A(k-2) from the model; check the 0x0000FF→0x0001FE and 0x00FF00 boundaries.
- **Wrap.** FTW=0x800000. Required outputs: 0x000000, 0x800000, 0x000000 with o_wrap=1, 0x800000 with o_wrap=0, …
- **Coherent FTW change.** Change FTW 0x010101→0x020202 mid-run. The output delta changes from 0x010101 to 0x020202 in exactly one step, with no intermediate delta. o_ftw_ready is low for 2 cycles.
- **Stall and clear.** Drop i_acc_en for 5 cycles during staging: outputs hold and ready stays low. Then assert i_acc_clr: next cycle the outputs are 0, o_valid=0, the new FTW is fully in force and ready=1.
- **Reset mid-staging.** Accept FTW=0xABCDEF, assert i_rst one cycle later. All outputs are 0, ready=1, and the following run with FTW=0 stays at 0.

Source files
------------

// File: rtl/phase_accumulator_if.sv
// phase_accumulator_if: FTW handshake, step controls and sliced phase outputs.
interface phase_accumulator_if;
    logic [23:0] i_ftw;
    logic        i_ftw_valid;
    logic        o_ftw_ready;
    logic        i_acc_en;
    logic        i_acc_clr;
    logic [7:0]  o_msb;
    logic [7:0]  o_isb;
    logic [7:0]  o_lsb;
    logic        o_valid;
    logic        o_wrap;
    modport slave (
        input  i_ftw, i_ftw_valid, i_acc_en, i_acc_clr,
        output o_ftw_ready, o_msb, o_isb, o_lsb, o_valid, o_wrap
    );
    modport master (
        output i_ftw, i_ftw_valid, i_acc_en, i_acc_clr,
        input  o_ftw_ready, o_msb, o_isb, o_lsb, o_valid, o_wrap
    );
endinterface

// File: rtl/phase_accumulator.sv
// phase_accumulator: 24-bit DDS phase accumulator built from three carry-pipelined 8-bit slices.
module phase_accumulator (
    input  logic                i_clk,
    input  logic                i_rst,
    phase_accumulator_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, STAGE_I, STAGE_M} state_e;
    state_e       state_q, state_d;
    logic [23:8]  pend_q, pend_d;
    logic [7:0]   fl_q, fl_d, fi_q, fi_d, fm_q, fm_d;
    logic [7:0]   l_q, i_q, m_q, l1_q, l2_q, i1_q;
    logic         c0_q, c1_q, cw_q;
    logic [1:0]   fill_q;
    logic         accept;
    logic [8:0]   l_sum, i_sum, m_sum;

    assign accept = bus.i_ftw_valid && state_q == IDLE;
    assign l_sum  = {1'b0, l_q} + {1'b0, fl_q};
    assign i_sum  = {1'b0, i_q} + {1'b0, fi_q} + {8'd0, c0_q};
    assign m_sum  = {1'b0, m_q} + {1'b0, fm_q} + {8'd0, c1_q};

    // Each slice lags the one below by a step, so the FTW bytes follow the same stagger.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        fl_d    = fl_q;
        fi_d    = fi_q;
        fm_d    = fm_q;
        if (accept) begin
            fl_d    = bus.i_ftw[7:0];
            pend_d  = bus.i_ftw[23:8];
            state_d = STAGE_I;
        end
        if (bus.i_acc_clr) begin
            fi_d    = pend_d[15:8];
            fm_d    = pend_d[23:16];
            state_d = IDLE;
        end else if (bus.i_acc_en && state_q == STAGE_I) begin
            fi_d    = pend_q[15:8];
            state_d = STAGE_M;
        end else if (bus.i_acc_en && state_q == STAGE_M) begin
            fm_d    = pend_q[23:16];
            state_d = IDLE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            fl_q    <= '0;
            fi_q    <= '0;
            fm_q    <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            fl_q    <= fl_d;
            fi_q    <= fi_d;
            fm_q    <= fm_d;
        end
    end

    // fill_q gates the upper slices until their inputs hold defined accumulator bytes.
    always_ff @(posedge i_clk) begin
        if (i_rst || bus.i_acc_clr) begin
            l_q    <= '0;
            i_q    <= '0;
            m_q    <= '0;
            l1_q   <= '0;
            l2_q   <= '0;
            i1_q   <= '0;
            c0_q   <= 1'b0;
            c1_q   <= 1'b0;
            cw_q   <= 1'b0;
            fill_q <= '0;
        end else if (bus.i_acc_en) begin
            {c0_q, l_q} <= l_sum;
            l1_q   <= l_q;
            l2_q   <= l1_q;
            i1_q   <= i_q;
            fill_q <= {fill_q[0], 1'b1};
            if (fill_q[0]) {c1_q, i_q} <= i_sum;
            if (fill_q[1]) {cw_q, m_q} <= m_sum;
        end
    end

    assign bus.o_ftw_ready = state_q == IDLE;
    assign bus.o_msb       = m_q;
    assign bus.o_isb       = i1_q;
    assign bus.o_lsb       = l2_q;
    assign bus.o_valid     = fill_q[1];
    assign bus.o_wrap      = cw_q;
endmodule

// File: tb/tb_phase_accumulator.sv
// tb_phase_accumulator: random and directed stimulus against a phase-history model of the accumulator.
module tb_phase_accumulator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    phase_accumulator_if bus();
    phase_accumulator dut (.i_clk(clk), .i_rst(rst), .bus(bus));
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [23:0] m_a[$];
    bit          m_w[$];
    logic [23:0] m_f;
    int          m_stage = 0;
    bit          m_acc = 1'b0;

    task automatic check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int phase();
        return int'({bus.o_msb, bus.o_isb, bus.o_lsb});
    endfunction

    // Model: history of A(k) since reset/clear, the FTW in force, and enabled steps left to stage.
    always @(posedge clk) begin
        logic [24:0] s;
        m_acc = !rst && bus.i_ftw_valid && m_stage == 0;
        if (rst) begin
            m_a = {24'd0};
            m_w = {1'b0};
            m_f = 24'd0;
            m_stage = 0;
        end else if (bus.i_acc_clr) begin
            m_a = {24'd0};
            m_w = {1'b0};
            if (m_acc) m_f = bus.i_ftw;
            m_stage = 0;
        end else begin
            if (bus.i_acc_en) begin
                s = {1'b0, m_a[$]} + {1'b0, m_f};
                m_a.push_back(s[23:0]);
                m_w.push_back(s[24]);
                if (m_stage > 0) m_stage--;
            end
            if (m_acc) begin
                m_f = bus.i_ftw;
                m_stage = 2;
            end
        end
    end

    initial begin
        int k;
        @(posedge clk);
        forever begin
            @(negedge clk);
            k = m_a.size() - 1;
            check("phase", phase(), k >= 2 ? int'(m_a[k-2]) : 0);
            check("valid", int'(bus.o_valid), int'(k >= 2));
            check("wrap", int'(bus.o_wrap), k >= 2 ? int'(m_w[k-2]) : 0);
            check("ready", int'(bus.o_ftw_ready), int'(m_stage == 0));
        end
    end

    initial begin
        int ramp_e[6] = '{0, 0, 0, 1, 2, 3};
        bit ramp_v[6] = '{0, 0, 1, 1, 1, 1};
        int wrap_e[6] = '{0, 0, 0, 'h800000, 0, 'h800000};
        bit wrap_w[6] = '{0, 0, 0, 0, 1, 0};
        int prev, cur, held, r;
        bus.i_ftw = 24'd0;
        bus.i_ftw_valid = 1'b0;
        bus.i_acc_en = 1'b0;
        bus.i_acc_clr = 1'b0;
        cyc(2);
        rst = 1'b0;
        check("rst_phase", phase(), 0);
        check("rst_valid", int'(bus.o_valid), 0);
        check("rst_wrap", int'(bus.o_wrap), 0);
        check("rst_ready", int'(bus.o_ftw_ready), 1);

        bus.i_ftw = 24'h000001;
        bus.i_ftw_valid = 1'b1;
        cyc();
        bus.i_ftw_valid = 1'b0;
        bus.i_acc_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) cyc();
            check("ramp", phase(), ramp_e[i]);
            check("ramp_valid", int'(bus.o_valid), int'(ramp_v[i]));
            check("ramp_ready", int'(bus.o_ftw_ready), int'(i >= 2));
        end

        bus.i_acc_clr = 1'b1;
        bus.i_ftw = 24'h800000;
        bus.i_ftw_valid = 1'b1;
        cyc();
        bus.i_acc_clr = 1'b0;
        bus.i_ftw_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) cyc();
            check("wrap_phase", phase(), wrap_e[i]);
            check("wrap_flag", int'(bus.o_wrap), int'(wrap_w[i]));
        end

        bus.i_acc_clr = 1'b1;
        bus.i_ftw = 24'h0000FF;
        bus.i_ftw_valid = 1'b1;
        cyc();
        bus.i_acc_clr = 1'b0;
        bus.i_ftw_valid = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            cyc();
            if (i == 3) check("carry_0ff", phase(), 'h0000FF);
            if (i == 4) check("carry_1fe", phase(), 'h0001FE);
            if (i == 258) check("carry_ff00", phase(), 'h00FF00);
        end

        bus.i_acc_clr = 1'b1;
        bus.i_ftw = 24'h010101;
        bus.i_ftw_valid = 1'b1;
        cyc();
        bus.i_acc_clr = 1'b0;
        bus.i_ftw_valid = 1'b0;
        cyc(6);
        bus.i_ftw = 24'h020202;
        bus.i_ftw_valid = 1'b1;
        cyc();
        bus.i_ftw_valid = 1'b0;
        check("coh_ready0", int'(bus.o_ftw_ready), 0);
        prev = phase();
        for (int j = 1; j <= 8; j++) begin
            cyc();
            cur = phase();
            check("coh_delta", (cur - prev) & 'hFFFFFF, j >= 3 ? 'h020202 : 'h010101);
            check("coh_ready", int'(bus.o_ftw_ready), int'(j >= 2));
            prev = cur;
        end

        bus.i_ftw = 24'h123456;
        bus.i_ftw_valid = 1'b1;
        cyc();
        bus.i_ftw_valid = 1'b0;
        bus.i_acc_en = 1'b0;
        held = phase();
        for (int j = 0; j < 5; j++) begin
            cyc();
            check("stall_hold", phase(), held);
            check("stall_ready", int'(bus.o_ftw_ready), 0);
        end
        bus.i_acc_clr = 1'b1;
        cyc();
        bus.i_acc_clr = 1'b0;
        check("clr_phase", phase(), 0);
        check("clr_valid", int'(bus.o_valid), 0);
        check("clr_ready", int'(bus.o_ftw_ready), 1);
        bus.i_acc_en = 1'b1;
        cyc(3);
        check("clr_ftw", phase(), 'h123456);

        bus.i_ftw = 24'hABCDEF;
        bus.i_ftw_valid = 1'b1;
        cyc();
        bus.i_ftw_valid = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("mrst_phase", phase(), 0);
        check("mrst_ready", int'(bus.o_ftw_ready), 1);
        check("mrst_valid", int'(bus.o_valid), 0);
        for (int j = 0; j < 6; j++) begin
            cyc();
            check("mrst_zero", phase(), 0);
        end

        for (int i = 0; i < 3000; i++) begin
            bus.i_acc_en = $urandom_range(3) != 0;
            bus.i_acc_clr = $urandom_range(40) == 0;
            rst = $urandom_range(300) == 0;
            if (bus.i_ftw_valid && m_acc) bus.i_ftw_valid = 1'b0;
            if (!bus.i_ftw_valid && $urandom_range(3) == 0) begin
                r = $urandom_range(3);
                bus.i_ftw = r == 0 ? 24'hFFFFFF : r == 1 ? 24'($urandom_range(255)) : 24'($urandom);
                bus.i_ftw_valid = 1'b1;
            end
            cyc();
        end
        rst = 1'b0;
        bus.i_ftw_valid = 1'b0;
        bus.i_acc_clr = 1'b0;
        cyc(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
